// File: rtl/ps2_pkg.sv
// Shared types and PS/2 frame constants for the keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STOP  = 2'd2
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // Odd parity holds when the data bits plus the parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Small synchronous FIFO for scan-code bytes; the head is read-through and reads 0 when empty.
module kbd_fifo
    import ps2_pkg::*;
#(
    parameter int AW = 3,
    parameter int DW = DATA_BITS
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign o_count = r_count;
    assign o_full  = (r_count == DEPTH);
    assign o_empty = (r_count == '0);

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees the slot.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write.
    // NOTE: the array has no reset; an empty count already hides stale entries, and a resettable array would cost a flop per bit.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at 2**AW.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deserialises and validates 11-bit
// frames, and queues good bytes for the bus read path.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rdn,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [2:0]             r_clk_sync;
    logic [2:0]             r_dat_sync;
    rx_state_t              r_state;
    rx_state_t              w_next_state;
    logic [DATA_BITS:0]     r_shift;
    logic [3:0]             r_bit_cnt;
    logic [TW-1:0]          r_to_cnt;
    logic                   r_push;
    logic [DATA_BITS-1:0]   r_push_byte;
    logic                   r_frame_err;
    logic                   r_rdn_q;
    logic                   r_overflow;

    logic                   w_fall;
    logic                   w_bit;
    logic                   w_timeout;
    logic                   w_good;
    logic                   w_err;
    logic                   w_pop;
    logic [DATA_BITS-1:0]   w_head;
    logic [FIFO_AW:0]       w_count;
    logic                   w_full;
    logic                   w_empty;

    assign w_fall = !r_clk_sync[1] && r_clk_sync[2];
    assign w_bit  = r_dat_sync[1];
    assign w_pop  = !rdn && r_rdn_q;

    assign data      = w_head;
    assign ready     = (w_count != '0);
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

    // Three-flop synchronisers for the asynchronous PS/2 lines; idle level is high.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 3'b111;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[1:0], ps2_data};
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and frame verdict.
    // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_good       = 1'b0;
        w_err        = 1'b0;
        w_timeout    = (r_state != ST_IDLE) && !w_fall && (r_to_cnt == TO_LAST);
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    if (w_bit == START_BIT) w_next_state = ST_SHIFT;
                    else                    w_err        = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_fall && r_bit_cnt == 4'(DATA_BITS)) w_next_state = ST_STOP;
            end
            ST_STOP: begin
                if (w_fall) begin
                    w_next_state = ST_IDLE;
                    if (w_bit == STOP_BIT && odd_parity_ok(r_shift[DATA_BITS-1:0], r_shift[DATA_BITS]))
                        w_good = 1'b1;
                    else
                        w_err = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_next_state = ST_IDLE;
            w_err        = 1'b1;
            w_good       = 1'b0;
        end
    end

    // LSB-first deserialiser: after nine shifts the byte sits in [7:0] and parity in [8].
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_fall) begin
            if (r_state == ST_IDLE) begin
                r_bit_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_shift   <= {w_bit, r_shift[DATA_BITS:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end
    end

    // Inter-edge timeout counter: held at zero in IDLE, restarted by every falling edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                             r_to_cnt <= '0;
        else if (r_state == ST_IDLE || w_fall) r_to_cnt <= '0;
        else                                   r_to_cnt <= r_to_cnt + TW'(1);
    end

    // Registered push, error pulse, read-strobe edge detect and sticky overflow.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_push      <= 1'b0;
            r_push_byte <= '0;
            r_frame_err <= 1'b0;
            r_rdn_q     <= 1'b1;
            r_overflow  <= 1'b0;
        end else begin
            r_push      <= w_good;
            r_push_byte <= r_shift[DATA_BITS-1:0];
            r_frame_err <= w_err;
            r_rdn_q     <= rdn;
            if (w_pop && !w_empty)              r_overflow <= 1'b0;
            else if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    kbd_fifo #(
        .AW (FIFO_AW),
        .DW (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .i_push  (r_push),
        .i_din   (r_push_byte),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver that feeds the I/O-space read path of the memory/IO bus.
- Synchronises the keyboard's PS/2 clock and data lines and deserialises 11-bit frames.
- Validates each frame and queues good scan-code bytes in a small FIFO.
- Presents the head byte plus a ready flag to the bus; the bus pops one byte per active-low read strobe.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW (8 entries).
TIMEOUT_CYC, 200000, clk cycles without a ps2_clk falling edge before a partial frame is discarded (2 ms at 100 MHz).

Ports:
clk  input  1  system clock, all state updates on rising edge.
clrn  input  1  asynchronous active-low reset.
ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous.
ps2_data  input  1  raw PS/2 data from keyboard, asynchronous.
rdn  input  1  read strobe from bus, active low; may stay low for several cycles.
data  output  8  FIFO head byte; 8'h00 when empty.
ready  output  1  1 when FIFO is non-empty.
overflow  output  1  sticky: a good byte was dropped because the FIFO was full.
frame_err  output  1  one-cycle pulse when a frame is rejected (bad start, parity, stop, or timeout).

Behaviour:
- Reset (clrn=0, asynchronous):
  - FIFO pointers and count = 0; ready=0, data=8'h00, overflow=0, frame_err=0.
  - Receiver returns to IDLE; synchronisers are loaded with 1.
- Input sync: ps2_clk and ps2_data each pass through a 3-flop synchroniser.
- Edge detect: a falling edge is detected when sync stage 2 = 0 and stage 3 = 1. Data is sampled from sync stage 2 on that cycle.
- Receiver FSM:
  - IDLE: on falling edge with data=0 (start bit), go to SHIFT with bit count 0. A falling edge with data=1 pulses frame_err and stays in IDLE.
  - SHIFT: each falling edge shifts data in LSB-first. Bits 0-7 form the byte, bit 8 is parity. After bit 8, go to STOP.
  - STOP: on the next falling edge, the frame is good if stop=1 and XOR(byte, parity)=1 (odd parity).
    - Good frame: push the byte, return to IDLE.
    - Bad frame: pulse frame_err, discard, return to IDLE.
  - Timeout: a counter resets on every falling edge and counts only outside IDLE. When it reaches TIMEOUT_CYC-1, pulse frame_err and go to IDLE.
- Push happens the cycle after the stop-bit edge is detected.
- Pop detection: rdn_q is a registered copy of rdn, reset to 1. A pop occurs on the cycle where rdn=0 and rdn_q=1, i.e. exactly one pop per low assertion regardless of its length.
  - A pop while empty is ignored.
- data and ready are combinational from FIFO head and count. The bus samples the head during the low strobe; the head advances on the clock edge of the pop.
- Latency: the last ps2_clk falling edge (stop bit) to ready=1 is 4-5 clk cycles (3 sync + push).
- Full FIFO with push and no pop: byte dropped, overflow set to 1.
- Full FIFO with push and pop on the same cycle: both take effect, count unchanged, no overflow.
- Empty FIFO with push and pop on the same cycle: the pop is ignored and the push takes effect.
- overflow is cleared by any successful pop.
- Pointers wrap modulo 2**FIFO_AW. Count is FIFO_AW+1 bits wide and saturates at depth.
- Reset mid-frame drops the partial frame and clears the FIFO contents.

Decomposition:
- Shared package ps2_pkg:
  - FSM state enum (IDLE, SHIFT, STOP).
  - Frame constants: START_BIT=0, STOP_BIT=1, DATA_BITS=8.
- Sub-module kbd_fifo: synchronous FIFO with push, pop, head, count, full and empty; read-through head.
- The receiver FSM, synchroniser and timeout counter stay in ps2_kbd_rx.

Test Plan:
- Single frame: byte 8'h1C, parity 0, stop 1 -> ready=1 within 5 clk after the stop edge; data=8'h1C. Pulse rdn low for 3 cycles -> exactly one pop; ready=0, data=8'h00.
- Break sequence: frames 8'hF0 then 8'h1C, no reads -> count=2, data=8'hF0. First rdn pulse -> data=8'h1C; second pulse -> ready=0.
- Parity error: byte 8'h1C with parity 1 -> frame_err pulses once, ready stays 0. A following good 8'h32 is received normally.
- Overflow: 9 good frames 8'h01..8'h09 with no reads -> overflow=1, 8 entries 8'h01..8'h08 are readable in order. overflow=0 after the first pop.
- Timeout: start bit plus 4 data bits, then idle for TIMEOUT_CYC cycles -> frame_err pulses, FSM in IDLE. A next full frame 8'h5A is received correctly.
- Reset and simultaneous events: clrn=0 mid-frame with FIFO holding 3 bytes -> ready=0 immediately and the partial frame is discarded. Full FIFO with push coinciding with a pop edge -> count stays 8, overflow=0.
